// File: rtl/orientation_debounce.sv
// Debounces a 4-bit orientation code: a new code must repeat STABLE_COUNT valid samples
// before it is committed, then HOLD_SAMPLES valid samples are ignored.
module orientation_debounce #(
    parameter int unsigned STABLE_COUNT = 8,
    parameter int unsigned HOLD_SAMPLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_valid,
    input  logic [3:0] orientation_in,
    output logic [3:0] orientation_out,
    output logic       changed,
    output logic       pending,
    output logic       holding,
    output logic       code_err
);

    typedef enum logic [1:0] {
        IDLE,
        CAND,
        HOLD
    } state_t;

    localparam logic [7:0] SC8 = 8'(STABLE_COUNT);
    localparam logic [7:0] HS8 = 8'(HOLD_SAMPLES);

    state_t     state, state_nx;
    logic [3:0] cand, cand_nx;
    logic [3:0] out_nx;
    logic [3:0] code;
    logic [3:0] commit_code;
    logic [7:0] count, count_nx;
    logic [7:0] hcnt, hcnt_nx;
    logic       commit;
    logic       bad_code;

    assign bad_code = orientation_in > 4'd8;
    assign code     = bad_code ? '0 : orientation_in;
    assign pending  = (state == CAND);
    assign holding  = (state == HOLD);

    always_comb begin
        state_nx    = state;
        cand_nx     = cand;
        count_nx    = count;
        hcnt_nx     = hcnt;
        out_nx      = orientation_out;
        commit      = 1'b0;
        commit_code = cand;
        if (sample_valid) begin
            case (state)
                IDLE: begin
                    if (code != orientation_out) begin
                        if (SC8 == 8'd1) begin
                            commit      = 1'b1;
                            commit_code = code;
                        end else begin
                            state_nx = CAND;
                            cand_nx  = code;
                            count_nx = 8'd1;
                        end
                    end
                end
                CAND: begin
                    if (code == cand) begin
                        if (count + 8'd1 == SC8) begin
                            commit      = 1'b1;
                            commit_code = cand;
                        end else begin
                            count_nx = count + 8'd1;
                        end
                    end else if (code == orientation_out) begin
                        // excursion back to the committed code is discarded silently
                        state_nx = IDLE;
                        count_nx = '0;
                    end else if (SC8 == 8'd1) begin
                        commit      = 1'b1;
                        commit_code = code;
                    end else begin
                        cand_nx  = code;
                        count_nx = 8'd1;
                    end
                end
                HOLD: begin
                    if (hcnt + 8'd1 == HS8) begin
                        state_nx = IDLE;
                        hcnt_nx  = '0;
                    end else begin
                        hcnt_nx = hcnt + 8'd1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
        if (commit) begin
            out_nx   = commit_code;
            cand_nx  = commit_code;
            count_nx = '0;
            hcnt_nx  = '0;
            state_nx = (HS8 != 8'd0) ? HOLD : IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cand            <= '0;
            count           <= '0;
            hcnt            <= '0;
            orientation_out <= '0;
            changed         <= 1'b0;
            code_err        <= 1'b0;
        end else begin
            state           <= state_nx;
            cand            <= cand_nx;
            count           <= count_nx;
            hcnt            <= hcnt_nx;
            orientation_out <= out_nx;
            changed         <= commit;
            if (sample_valid && bad_code) begin
                code_err <= 1'b1;
            end
        end
    end

endmodule
